// File: rtl/stream_fifo_if.sv
// rtl/stream_fifo_if.sv - valid/ready handshake bundle between producer, stream_fifo and consumer
//
// Signals:
//   up_valid   producer has data            up_ready   FIFO can accept
//   up_data    producer payload             down_valid FIFO holds data
//   down_ready consumer accepts             down_data  head entry
//   level      occupancy, only when STREAM_FIFO_LEVEL_EN is defined
// Modports:
//   slave  - the FIFO's view (drives up_ready, down_valid, down_data, level)
//   master - the surrounding environment's view (drives up_valid, up_data, down_ready)
interface stream_fifo_if #(
    parameter int D_WIDTH = 6,
    parameter int DEPTH   = 4
);
    logic               up_valid;
    logic               up_ready;
    logic [D_WIDTH-1:0] up_data;
    logic               down_valid;
    logic               down_ready;
    logic [D_WIDTH-1:0] down_data;
`ifdef STREAM_FIFO_LEVEL_EN
    localparam int LW = $clog2(DEPTH) + 1;
    logic [LW-1:0]      level;
`endif

    modport slave (
        input  up_valid,
        input  up_data,
        input  down_ready,
        output up_ready,
        output down_valid,
        output down_data
`ifdef STREAM_FIFO_LEVEL_EN
        , output level
`endif
    );

    modport master (
        output up_valid,
        output up_data,
        output down_ready,
        input  up_ready,
        input  down_valid,
        input  down_data
`ifdef STREAM_FIFO_LEVEL_EN
        , input level
`endif
    );
endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - registered-flag valid/ready FIFO decoupling producer bursts from consumer back-pressure
//
// Parameters:
//   D_WIDTH  payload width in bits
//   DEPTH    entry count, power of two, >= 2
// Ports:
//   clk      single clock, all logic on posedge
//   rst      synchronous, active-high reset; discards all contents
//   bus      stream_fifo_if.slave: up_valid/up_ready/up_data in, down_valid/down_ready/down_data out,
//            plus level (occupancy 0..DEPTH) when STREAM_FIFO_LEVEL_EN is defined
// Configuration macro:
//   STREAM_FIFO_LEVEL_EN  adds the registered occupancy output and its logic
module stream_fifo #(
    parameter int D_WIDTH = 6,
    parameter int DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    stream_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [D_WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;

    logic up_ready_q;
    logic down_valid_q;
    logic push;
    logic pop;
    logic full_nxt;
    logic empty_nxt;

    // Handshakes use only registered flags, so a pop on a full FIFO cannot
    // free a slot for a push in the same cycle, and a push into an empty
    // FIFO cannot be popped in the same cycle.
    assign push = bus.up_valid & up_ready_q;
    assign pop  = down_valid_q & bus.down_ready;

    assign wr_ptr_nxt = push ? (wr_ptr + PTR_ONE) : wr_ptr;
    assign rd_ptr_nxt = pop  ? (rd_ptr + PTR_ONE) : rd_ptr;

    assign full_nxt  = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                       (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    assign empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            up_ready_q   <= 1'b0;
            down_valid_q <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            up_ready_q   <= ~full_nxt;
            down_valid_q <= ~empty_nxt;
        end
    end

    // Storage is not reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[AW-1:0]] <= bus.up_data;
        end
    end

    assign bus.up_ready   = up_ready_q;
    assign bus.down_valid = down_valid_q;
    // Head entry is addressed by a register, so it holds while stalled.
    assign bus.down_data  = mem[rd_ptr[AW-1:0]];

`ifdef STREAM_FIFO_LEVEL_EN
    logic [PW-1:0] level_q;

    // Pointer difference in modulo-2*DEPTH arithmetic gives 0..DEPTH directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= wr_ptr_nxt - rd_ptr_nxt;
        end
    end

    assign bus.level = level_q;
`endif
endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - self-checking bench for stream_fifo: directed vector table plus randomized scoreboard
module tb_stream_fifo;
    localparam int D_WIDTH = 6;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    stream_fifo_if #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH)) bus ();

    stream_fifo #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       uv;
        logic [5:0] ud;
        logic       dr;
        logic       e_ur;
        logic       e_dv;
        logic       chk_d;
        logic [5:0] e_d;
        int         e_lvl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string name, input logic r, input logic uv, input logic [5:0] ud,
                                input logic dr, input logic e_ur, input logic e_dv, input logic chk_d,
                                input logic [5:0] e_d, input int e_lvl);
        vec_t v;
        v.name = name; v.rst = r; v.uv = uv; v.ud = ud; v.dr = dr;
        v.e_ur = e_ur; v.e_dv = e_dv; v.chk_d = chk_d; v.e_d = e_d; v.e_lvl = e_lvl;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic uv, input logic [5:0] ud, input logic dr);
        rst            = r;
        bus.up_valid   = uv;
        bus.up_data    = ud;
        bus.down_ready = dr;
    endtask

    task automatic check_outputs(input string name, input logic e_ur, input logic e_dv,
                                 input logic chk_d, input logic [5:0] e_d, input int e_lvl);
        check({name, ".up_ready"}, 32'(bus.up_ready), 32'(e_ur));
        check({name, ".down_valid"}, 32'(bus.down_valid), 32'(e_dv));
        if (chk_d) check({name, ".down_data"}, 32'(bus.down_data), 32'(e_d));
`ifdef STREAM_FIFO_LEVEL_EN
        check({name, ".level"}, 32'(bus.level), 32'(e_lvl));
`else
        if (e_lvl < 0) check({name, ".level_range"}, 32'(e_lvl), 32'(0));
`endif
    endtask

    // Reference model: FIFO contents as a queue, flags derived from its size.
    logic [5:0] q[$];
    logic       m_ur;
    logic       m_dv;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b1, 1'b0, 6'h00, 1'b0);

        // Reset with producer active, then release.
        for (int i = 0; i < 3; i++) add("reset", 1, 1, 6'h3F, 0, 0, 0, 0, 6'h00, 0);
        add("release", 0, 0, 6'h00, 0, 1, 0, 0, 6'h00, 0);
        // Single word, no fall-through.
        add("single_push", 0, 1, 6'h2A, 1, 1, 1, 1, 6'h2A, 1);
        add("single_pop",  0, 0, 6'h00, 1, 1, 0, 0, 6'h00, 0);
        // Fill to DEPTH; the fifth word is refused.
        add("fill1", 0, 1, 6'h01, 0, 1, 1, 1, 6'h01, 1);
        add("fill2", 0, 1, 6'h02, 0, 1, 1, 1, 6'h01, 2);
        add("fill3", 0, 1, 6'h03, 0, 1, 1, 1, 6'h01, 3);
        add("fill4", 0, 1, 6'h04, 0, 0, 1, 1, 6'h01, 4);
        add("full_hold1", 0, 1, 6'h05, 0, 0, 1, 1, 6'h01, 4);
        add("full_hold2", 0, 1, 6'h05, 0, 0, 1, 1, 6'h01, 4);
        // Pop from full: no push that edge, push accepted the cycle after.
        add("full_pop",   0, 1, 6'h05, 1, 1, 1, 1, 6'h02, 3);
        add("after_pop",  0, 1, 6'h05, 0, 0, 1, 1, 6'h02, 4);
        add("drain1", 0, 0, 6'h00, 1, 1, 1, 1, 6'h03, 3);
        add("drain2", 0, 0, 6'h00, 1, 1, 1, 1, 6'h04, 2);
        add("drain3", 0, 0, 6'h00, 1, 1, 1, 1, 6'h05, 1);
        add("drain4", 0, 0, 6'h00, 1, 1, 0, 0, 6'h00, 0);
        // Reset with data inside and a pop requested discards everything.
        add("mid_push1", 0, 1, 6'h0A, 0, 1, 1, 1, 6'h0A, 1);
        add("mid_push2", 0, 1, 6'h0B, 0, 1, 1, 1, 6'h0A, 2);
        add("mid_rst",   1, 1, 6'h0C, 1, 0, 0, 0, 6'h00, 0);
        add("mid_rel",   0, 0, 6'h00, 0, 1, 0, 0, 6'h00, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].uv, vecs[i].ud, vecs[i].dr);
            @(posedge clk); #1;
            check_outputs(vecs[i].name, vecs[i].e_ur, vecs[i].e_dv, vecs[i].chk_d, vecs[i].e_d, vecs[i].e_lvl);
        end

        // Streaming: one word in and one out per cycle, data wrapping 3F->00.
        for (int k = 0; k < 64; k++) begin
            logic [5:0] w;
            w = 6'((8'h30 + k) & 8'h3F);
            drive(1'b0, 1'b1, w, 1'b1);
            @(posedge clk); #1;
            check_outputs("stream", 1'b1, 1'b1, 1'b1, w, 1);
        end
        drive(1'b0, 1'b0, 6'h00, 1'b1);
        @(posedge clk); #1;
        check_outputs("stream_drain", 1'b1, 1'b0, 1'b0, 6'h00, 0);

        // Randomized traffic against the queue model, with resets at the start and mid-run.
        q.delete();
        m_ur = 1'b0;
        m_dv = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            logic       r, uv, dr, m_push, m_pop, stall;
            logic [5:0] ud, pre_head;
            r  = (c == 0) || (c == 500) || (c == 501);
            uv = ($urandom_range(0, 99) < 60);
            ud = 6'($urandom_range(0, 63));
            dr = ($urandom_range(0, 99) < 50);
            drive(r, uv, ud, dr);
            m_push   = !r && uv && m_ur;
            m_pop    = !r && dr && m_dv;
            stall    = !r && m_dv && !dr;
            pre_head = (q.size() > 0) ? q[0] : 6'h00;
            @(posedge clk); #1;
            if (r) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_push) q.push_back(ud);
            end
            m_ur = !r && (q.size() < DEPTH);
            m_dv = (q.size() > 0);
            check_outputs("random", m_ur, m_dv, m_dv, (q.size() > 0) ? q[0] : 6'h00, q.size());
            if (stall) check("random.stall_hold", 32'(bus.down_data), 32'(pre_head));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
